ram_pattern_checker: RTL and testbench

On-chip reader for the JTAG RAM test path. The host writes an arithmetic pattern into the test RAM over JTAG; this block reads the same region back over its own Wishbone master port, compares every word against the regenerated pattern, and reports pass/fail, an error count and the first mismatch. It sits beside the JTAG-to-Wishbone bridge inside the RAM test top, as a second master on the RAM's bus arbiter.

---
 rtl/ram_test_pkg.sv | 14 +
 rtl/ram_pattern_checker.sv | 144 ++++++++++++++
 tb/tb_ram_pattern_checker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the JTAG RAM test path: checker FSM states,
// bus width defaults common to the bridge and the test RAM, and the pattern step.
package ram_test_pkg;
  localparam int DW_DEFAULT  = 32;
  localparam int AW_DEFAULT  = 10;
  localparam int PATTERN_INC = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } chk_state_t;
endpackage

// File: rtl/ram_pattern_checker.sv
// Reads back a RAM region over Wishbone, one word at a time, and compares each word
// against the arithmetic pattern seed + i, reporting pass/fail, count and first mismatch.
module ram_pattern_checker
  import ram_test_pkg::*;
#(
  parameter int Dw   = DW_DEFAULT,
  parameter int Aw   = AW_DEFAULT,
  parameter int SELw = Dw / 8,
  parameter int Cw   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [Aw-1:0]   base_addr,
  input  logic [Aw:0]     len,
  input  logic [Dw-1:0]   seed,
  output logic [Aw-1:0]   m_adr_o,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [SELw-1:0] m_sel_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            bus_err,
  output logic [Cw-1:0]   err_cnt,
  output logic [Aw-1:0]   first_err_addr,
  output logic [Dw-1:0]   first_err_data
);

  chk_state_t state, next_state;

  logic [Aw:0]   len_r;
  logic [Aw:0]   idx;
  logic [Aw:0]   idx_inc;
  logic [Dw-1:0] exp_r;
  logic [Dw-1:0] rdata;
  logic          start_ok;
  logic          last_word;
  logic          mismatch;

  function automatic logic [Cw-1:0] sat_inc(input logic [Cw-1:0] v);
    return (&v) ? v : v + Cw'(1);
  endfunction

  always_comb begin
    start_ok  = start && (state == ST_IDLE || state == ST_DONE);
    idx_inc   = idx + (Aw+1)'(1);
    last_word = (idx_inc == len_r);
    mismatch  = (rdata != exp_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Error beats ack when a slave raises both in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = (len == '0) ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (m_err_i)      next_state = ST_DONE;
        else if (m_ack_i) next_state = ST_CMP;
      end
      ST_CMP:  next_state = last_word ? ST_DONE : ST_REQ;
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered bus and status outputs; cleared asynchronously so a bus cycle drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_adr_o        <= '0;
      m_cyc_o        <= 1'b0;
      m_stb_o        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus_err        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      m_cyc_o <= (next_state == ST_REQ);
      m_stb_o <= (next_state == ST_REQ);
      if (start_ok) begin
        m_adr_o        <= base_addr;
        busy           <= (len != '0);
        done           <= (len == '0);
        bus_err        <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else begin
        case (state)
          ST_REQ: begin
            if (m_err_i) begin
              bus_err <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
          ST_CMP: begin
            if (mismatch) begin
              err_cnt <= sat_inc(err_cnt);
              if (err_cnt == '0) begin
                first_err_addr <= m_adr_o;
                first_err_data <= rdata;
              end
            end
            m_adr_o <= m_adr_o + Aw'(1);
            if (last_word) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pattern generator and read capture; no reset needed, always loaded before use.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      len_r <= len;
      idx   <= '0;
      exp_r <= seed;
    end else if (state == ST_CMP) begin
      idx   <= idx_inc;
      exp_r <= exp_r + Dw'(PATTERN_INC);
    end
    if (state == ST_REQ && m_ack_i) rdata <= m_dat_i;
  end

  assign m_we_o  = 1'b0;
  assign m_sel_o = {SELw{m_stb_o}};
  assign pass    = done && !bus_err && (err_cnt == '0);

endmodule

// File: tb/tb_ram_pattern_checker.sv
// Self-checking bench for ram_pattern_checker: a wait-state/error-injecting RAM slave
// and a word-by-word reference model of the readback check.
module tb_ram_pattern_checker;
  localparam int Dw = 32, Aw = 10, SELw = 4, Cw = 16;

  logic clk = 1'b0;
  logic reset;
  logic start, start2;
  logic [Aw-1:0] base_addr;
  logic [Aw:0]   len;
  logic [Dw-1:0] seed;
  logic [Aw-1:0] m_adr_o;
  logic          m_cyc_o, m_stb_o, m_we_o, m_ack_i, m_err_i;
  logic [SELw-1:0] m_sel_o;
  logic [Dw-1:0] m_dat_i;
  logic          busy, done, pass, bus_err;
  logic [Cw-1:0] err_cnt;
  logic [Aw-1:0] first_err_addr;
  logic [Dw-1:0] first_err_data;

  logic [Aw-1:0] adr2, fa2;
  logic          cyc2, stb2, we2, busy2, done2, pass2, berr2;
  logic [SELw-1:0] sel2;
  logic [1:0]    cnt2;
  logic [Dw-1:0] fd2;

  always #5 clk = ~clk;

  ram_pattern_checker #(.Dw(Dw), .Aw(Aw), .SELw(SELw), .Cw(Cw)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len), .seed(seed),
    .m_adr_o(m_adr_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .busy(busy), .done(done), .pass(pass), .bus_err(bus_err), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  // Narrow-counter instance reading an all-zero zero-wait slave, for saturation.
  ram_pattern_checker #(.Dw(Dw), .Aw(Aw), .SELw(SELw), .Cw(2)) u_sat (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr), .len(len), .seed(seed),
    .m_adr_o(adr2), .m_cyc_o(cyc2), .m_stb_o(stb2), .m_we_o(we2), .m_sel_o(sel2),
    .m_dat_i('0), .m_ack_i(stb2), .m_err_i(1'b0),
    .busy(busy2), .done(done2), .pass(pass2), .bus_err(berr2), .err_cnt(cnt2),
    .first_err_addr(fa2), .first_err_data(fd2)
  );

  // RAM slave model
  logic [Dw-1:0] mem [0:(1<<Aw)-1];
  int wait_states, err_at, rd_num, stb_cycles, wait_cnt;
  logic ack_force;
  logic [Aw-1:0] addr_log[$];

  assign m_ack_i = ack_force | (m_stb_o && wait_cnt == wait_states);
  assign m_err_i = m_stb_o && wait_cnt == wait_states && rd_num == err_at;
  assign m_dat_i = mem[m_adr_o];

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!m_stb_o || m_ack_i || m_err_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (m_stb_o) stb_cycles <= stb_cycles + 1;
    if (m_stb_o && (m_ack_i || m_err_i)) rd_num <= rd_num + 1;
    if (m_stb_o && m_ack_i && !m_err_i) addr_log.push_back(m_adr_o);
  end

  int n_cmp, n_fail;
  int cyc;
  logic busy1;
  logic [SELw-1:0] sel1;

  // Reference model
  int unsigned exp_cnt;
  logic [Aw-1:0] exp_fa;
  logic [Dw-1:0] exp_fd;
  logic exp_berr;
  int exp_cycles;
  logic [Aw-1:0] exp_addrs[$];

  task automatic model_run(input logic [Aw-1:0] b, input int l, input logic [Dw-1:0] s);
    exp_cnt = 0; exp_fa = '0; exp_fd = '0; exp_berr = 1'b0; exp_cycles = 1;
    exp_addrs.delete();
    for (int i = 0; i < l; i++) begin
      logic [Aw-1:0] a;
      logic [Dw-1:0] e;
      a = b + Aw'(i);
      e = s + Dw'(i);
      if (i == err_at) begin
        exp_berr = 1'b1;
        exp_cycles += 1 + wait_states;
        break;
      end
      exp_addrs.push_back(a);
      exp_cycles += 2 + wait_states;
      if (mem[a] !== e) begin
        if (exp_cnt == 0) begin exp_fa = a; exp_fd = mem[a]; end
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
  endtask

  task automatic fill_pattern(input logic [Aw-1:0] b, input int l, input logic [Dw-1:0] s);
    for (int i = 0; i < l; i++) mem[b + Aw'(i)] = s + Dw'(i);
  endtask

  // Starts a check and returns with cyc = index of the cycle done was first seen
  // (1 = the cycle right after the accepting edge).
  task automatic run(input logic [Aw-1:0] b, input int l, input logic [Dw-1:0] s, input int restart_at);
    @(negedge clk);
    base_addr = b; len = (Aw+1)'(l); seed = s; start = 1'b1;
    addr_log.delete(); rd_num = 0; stb_cycles = 0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; busy1 = busy; sel1 = m_sel_o;
    while (!done && cyc < 4000) begin
      if (cyc == restart_at) begin start = 1'b1; len = (Aw+1)'(1); seed = ~s; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: done still %0b after %0d cycles, want 1", done, cyc);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, pass, bus_err, m_cyc_o, m_stb_o, m_we_o} !== 7'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, pass, bus_err, m_cyc_o, m_stb_o, m_we_o}); end
    n_cmp++; if ({err_cnt, first_err_addr, first_err_data, m_adr_o, m_sel_o} !== '0) begin n_fail++; $display("FAIL reset_values: cnt %h fa %h fd %h adr %h sel %h want all 0", err_cnt, first_err_addr, first_err_data, m_adr_o, m_sel_o); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, done, m_cyc_o, done2} !== 4'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0000", {busy, done, m_cyc_o, done2}); end
  endtask

  task automatic test_pass;
    wait_states = 0; err_at = -1;
    fill_pattern(0, 4, 32'h1000_0000);
    run(0, 4, 32'h1000_0000, -1);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL pass_done_cycle: got %0d want 9", cyc); end
    n_cmp++; if ({done, pass, busy, bus_err} !== 4'b1100) begin n_fail++; $display("FAIL pass_flags: got %b want 1100", {done, pass, busy, bus_err}); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL pass_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if ({busy1, sel1} !== 5'b1_1111) begin n_fail++; $display("FAIL pass_busy_sel: got %b want 11111", {busy1, sel1}); end
    n_cmp++; if (addr_log.size() !== 4) begin n_fail++; $display("FAIL pass_reads: got %0d want 4", addr_log.size()); end
  endtask

  task automatic test_mismatch;
    fill_pattern(0, 4, 32'h1000_0000);
    mem[2] = 32'hDEAD_BEEF;
    run(0, 4, 32'h1000_0000, -1);
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL mm_err_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (first_err_addr !== 10'd2) begin n_fail++; $display("FAIL mm_first_addr: got %h want 002", first_err_addr); end
    n_cmp++; if (first_err_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mm_first_data: got %h want deadbeef", first_err_data); end
    n_cmp++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL mm_done_pass: got %b want 10", {done, pass}); end
  endtask

  task automatic test_reset_mid;
    wait_states = 3; err_at = -1;
    @(negedge clk);
    base_addr = 10'd5; len = 11'd4; seed = 32'h0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if ({m_cyc_o, m_stb_o, busy} !== 3'b111) begin n_fail++; $display("FAIL rmid_in_req: got %b want 111", {m_cyc_o, m_stb_o, busy}); end
    reset = 1'b1; #1;
    n_cmp++; if ({m_cyc_o, m_stb_o, m_sel_o, busy, done, pass, bus_err} !== 10'b0) begin n_fail++; $display("FAIL rmid_drop: got %b want 0", {m_cyc_o, m_stb_o, m_sel_o, busy, done, pass, bus_err}); end
    n_cmp++; if ({err_cnt, first_err_addr, first_err_data} !== '0) begin n_fail++; $display("FAIL rmid_status: cnt %h fa %h fd %h want 0", err_cnt, first_err_addr, first_err_data); end
    @(negedge clk); reset = 1'b0; ack_force = 1'b1;
    @(negedge clk); ack_force = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if ({m_cyc_o, busy, done, bus_err, err_cnt} !== '0) begin n_fail++; $display("FAIL rmid_late_ack: got cyc %b busy %b done %b berr %b cnt %0d want 0", m_cyc_o, busy, done, bus_err, err_cnt); end
    wait_states = 0;
    run(10'd7, 0, 32'h55, -1);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_cycle: got %0d want 1", cyc); end
    n_cmp++; if ({done, pass, busy} !== 3'b110) begin n_fail++; $display("FAIL len0_flags: got %b want 110", {done, pass, busy}); end
    n_cmp++; if (stb_cycles !== 0) begin n_fail++; $display("FAIL len0_bus: got %0d strobes want 0", stb_cycles); end
  endtask

  task automatic test_wrap;
    logic [Dw-1:0] s;
    s = $urandom;
    wait_states = 0; err_at = -1;
    fill_pattern(10'h3FE, 4, s);
    run(10'h3FE, 4, s, -1);
    n_cmp++; if (addr_log.size() !== 4) begin n_fail++; $display("FAIL wrap_reads: got %0d want 4", addr_log.size()); end
    else begin
      n_cmp++; if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== {10'h3FE, 10'h3FF, 10'h000, 10'h001}) begin n_fail++; $display("FAIL wrap_addrs: got %h %h %h %h want 3fe 3ff 000 001", addr_log[0], addr_log[1], addr_log[2], addr_log[3]); end
    end
    n_cmp++; if ({done, pass, err_cnt} !== {2'b11, 16'd0}) begin n_fail++; $display("FAIL wrap_pass: got done %b pass %b cnt %0d want 1 1 0", done, pass, err_cnt); end
  endtask

  task automatic test_bus_err;
    wait_states = 1; err_at = 2;
    fill_pattern(10'd100, 6, 32'hA0);
    run(10'd100, 6, 32'hA0, -1);
    n_cmp++; if ({bus_err, done, pass, busy} !== 4'b1100) begin n_fail++; $display("FAIL berr_flags: got %b want 1100", {bus_err, done, pass, busy}); end
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL berr_cycle: got %0d want 9", cyc); end
    repeat (5) @(posedge clk); #1;
    n_cmp++; if ({rd_num, stb_cycles} !== {32'd3, 32'd6}) begin n_fail++; $display("FAIL berr_strobes: got %0d reads %0d strobe cycles want 3 and 6", rd_num, stb_cycles); end
    err_at = -1;
  endtask

  task automatic test_back_to_back;
    wait_states = 0; err_at = -1;
    fill_pattern(10'd40, 5, 32'h77);
    run(10'd40, 5, 32'h77, 3);
    n_cmp++; if (cyc !== 11) begin n_fail++; $display("FAIL busy_start_cycle: got %0d want 11", cyc); end
    n_cmp++; if ({pass, addr_log.size()} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL busy_start_run: got pass %b reads %0d want 1 5", pass, addr_log.size()); end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 2; k++) begin
      int l;
      int w;
      l = (k == 0) ? 6 : 2;
      @(negedge clk);
      base_addr = 10'd300; len = (Aw+1)'(l); seed = 32'd1; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      w = 0;
      while (!done2 && w < 100) begin @(negedge clk); w++; end
      n_cmp++; if (cnt2 !== ((k == 0) ? 2'd3 : 2'd2)) begin n_fail++; $display("FAIL sat_cnt_%0d: got %0d want %0d", l, cnt2, (k == 0) ? 3 : 2); end
      n_cmp++; if ({done2, pass2, fa2, fd2} !== {2'b10, 10'd300, 32'd0}) begin n_fail++; $display("FAIL sat_status_%0d: done %b pass %b fa %0d fd %h want 1 0 300 0", l, done2, pass2, fa2, fd2); end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic [Aw-1:0] b;
      logic [Dw-1:0] s;
      int l;
      b = Aw'($urandom);
      s = $urandom;
      l = $urandom_range(1, 24);
      wait_states = $urandom_range(0, 2);
      fill_pattern(b, l, s);
      for (int c = $urandom_range(0, 3); c > 0; c--)
        mem[b + Aw'($urandom_range(0, l - 1))] ^= (32'h1 << $urandom_range(0, 31));
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : -1;
      model_run(b, l, s);
      run(b, l, s, -1);
      n_cmp++; if (err_cnt !== Cw'(exp_cnt)) begin n_fail++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", it, err_cnt, exp_cnt); end
      n_cmp++; if ({first_err_addr, first_err_data} !== {exp_fa, exp_fd}) begin n_fail++; $display("FAIL rnd%0d_first: got %h/%h want %h/%h", it, first_err_addr, first_err_data, exp_fa, exp_fd); end
      n_cmp++; if ({bus_err, pass} !== {exp_berr, (exp_cnt == 0) && !exp_berr}) begin n_fail++; $display("FAIL rnd%0d_flags: got berr %b pass %b want %b %b", it, bus_err, pass, exp_berr, (exp_cnt == 0) && !exp_berr); end
      n_cmp++; if (cyc !== exp_cycles) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cyc, exp_cycles); end
      n_cmp++;
      if (addr_log.size() !== exp_addrs.size()) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d want %0d", it, addr_log.size(), exp_addrs.size()); end
      else begin
        for (int j = 0; j < exp_addrs.size(); j++)
          if (addr_log[j] !== exp_addrs[j]) begin n_fail++; $display("FAIL rnd%0d_addr%0d: got %h want %h", it, j, addr_log[j], exp_addrs[j]); break; end
      end
    end
    err_at = -1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; ack_force = 1'b0;
    base_addr = '0; len = '0; seed = '0;
    wait_states = 0; err_at = -1; rd_num = 0; stb_cycles = 0;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < (1 << Aw); i++) mem[i] = $urandom;
    test_reset;
    test_pass;
    test_mismatch;
    test_reset_mid;
    test_wrap;
    test_bus_err;
    test_back_to_back;
    test_saturate;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
